cmd_reply_packer: RTL and testbench
===================================

Name: cmd_reply_packer

Overview:
- Sits directly downstream of the in-band command reader on the TX clock.
- Collects the 16-bit reply words (ping replies, register-read replies) the command reader emits on its rx_WR/rx_databus port.
- Buffers them into a single reply payload and frames them as a fixed-format channel-0x1F packet (header, timestamp, payload).
- Writes the packet into the RX packet FIFO for return to the host.

Parameters:
- BUF_WORDS, 252: payload buffer depth in 16-bit words; max payload = 2*BUF_WORDS bytes.
- FLUSH_IDLE, 16: idle cycles after the last reply word before a partial packet is closed.
- CHAN, 5'h1F: channel number placed in the header.

Ports:
- txclk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- adc_time  in  32  sample-time counter, sampled as packet timestamp.
- rx_WR  in  1  reply word strobe from the command reader.
- rx_databus  in  16  reply word.
- rx_WR_done  in  1  level; high while the command reader is between commands.
- rx_WR_enabled  out  1  ready to accept a word pair.
- pkt_space  in  1  RX FIFO has room for ≥256 words.
- wrreq  out  1  RX FIFO write strobe.
- wrdata  out  16  RX FIFO write data.
- pkt_done  out  1  one-cycle pulse on the last word of a packet.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0 except rx_WR_enabled=1.
  - State=COLLECT, word count=0, overrun flag=0, idle counter=0.
- Word acceptance:
  - rx_WR_enabled = (state==COLLECT) && (count <= BUF_WORDS-2). This guarantees room for the low/high word pair, since the high word arrives the next cycle unconditionally.
  - On rx_WR with count<BUF_WORDS: store the word at buf[count] and increment count.
  - rx_WR when count==BUF_WORDS or state!=COLLECT: word is dropped and the overrun flag is set (sticky until that packet's header is written).
  - On the first stored word of a packet (count 0->1), latch adc_time as the timestamp.
- Close condition, evaluated in COLLECT:
  - count>=BUF_WORDS-1, OR
  - count>0 && rx_WR_done && idle counter==FLUSH_IDLE-1.
  - The idle counter clears on any rx_WR or while rx_WR_done=0, and saturates.
  - count==0 never closes.
  - On close, go to WAIT_SPACE.
- WAIT_SPACE: hold until pkt_space=1, then go to HDR. rx_WR_enabled stays 0 here.
- HDR: 4 consecutive wrreq cycles, no stalls:
  - w0 = {overrun, 6'd0, bytes[8:0]}, where bytes = 2*count.
  - w1 = {11'd0, CHAN}.
  - w2 = ts[15:0].
  - w3 = ts[31:16].
- DATA:
  - Emits buf[0..count-1] in order, one per cycle, with wrreq held high.
  - Buffer read is registered (1-cycle prefetch issued during w3), so wrdata stays gapless.
- PAD (feature dependent): see Optional Feature.
- pkt_done pulses with the final wrreq. Next cycle: count=0, overrun=0, state=COLLECT.
- wrdata is registered; wrreq and wrdata change only on txclk rising edge.
- Reset asserted mid-packet: wrreq drops immediately, the partial packet is abandoned, and the buffer is discarded. The downstream FIFO is reset by the same net.
- Simultaneous rx_WR and close condition on the same cycle: the word is stored first and counted in bytes.

Optional Feature:
- Macro: REPLY_PAD_EN.
- Defined: after DATA, write 16'h0000 until exactly 256 words (4+BUF_WORDS) have been written. pkt_done is on word 256. Packets are fixed 512 bytes.
- Undefined: PAD is skipped and pkt_done is on the last payload word. Packet length is 4+count words, and pkt_space still gates entry.

Test Plan:
- Ping reply:
  - Stimulus: words 16'h1234, 16'h0102 on consecutive cycles; rx_WR_done=1; pkt_space=1; adc_time=32'h0000_0100 at the first word.
  - Response after 16 idle cycles: wrdata 0x0004, 0x001F, 0x0100, 0x0000, 0x1234, 0x0102, then 250 zeros with REPLY_PAD_EN; pkt_done on word 256.
- Register read:
  - Stimulus: 4 words (two pairs) with rx_WR_done=0 between pairs.
  - Response: no close until rx_WR_done=1 plus 16 cycles; header w0=0x0008.
- Fill:
  - Stimulus: 126 pairs back-to-back.
  - Response: rx_WR_enabled falls after count=252; closes without timeout; w0=0x01F8; no pad words.
- Overrun:
  - Stimulus: rx_WR during WAIT_SPACE with pkt_space=0 for 50 cycles.
  - Response: word dropped; w0[15]=1 in that packet; next packet w0[15]=0.
- Backpressure: pkt_space=0 at close -> no wrreq until pkt_space=1, then 256 gapless writes.
- Reset mid-DATA:
  - Stimulus: assert reset at word 10.
  - Response: wrreq=0 same cycle; rx_WR_enabled=1 after release; next packet starts with a fresh timestamp and count.

Source files
------------

// File: rtl/cmd_reply_packer_if.sv
// Reply-word and RX-FIFO handshake bundle for cmd_reply_packer.
// master = packer side, slave = command reader / FIFO side.
interface cmd_reply_packer_if;
    logic        rx_WR;
    logic [15:0] rx_databus;
    logic        rx_WR_done;
    logic        rx_WR_enabled;
    logic        pkt_space;
    logic        wrreq;
    logic [15:0] wrdata;
    logic        pkt_done;

    modport master (
        input  rx_WR, rx_databus, rx_WR_done, pkt_space,
        output rx_WR_enabled, wrreq, wrdata, pkt_done
    );

    modport slave (
        output rx_WR, rx_databus, rx_WR_done, pkt_space,
        input  rx_WR_enabled, wrreq, wrdata, pkt_done
    );
endinterface

// File: rtl/cmd_reply_packer.sv
// Packs command-reader reply words into channel packets for the RX FIFO.
// Define REPLY_PAD_EN to zero-pad every packet to a fixed 256 words.
module cmd_reply_packer #(
    parameter int         BUF_WORDS  = 252,
    parameter int         FLUSH_IDLE = 16,
    parameter logic [4:0] CHAN       = 5'h1F
) (
    input  logic        txclk,
    input  logic        reset,
    input  logic [31:0] adc_time,
    cmd_reply_packer_if.master bus
);

    localparam int CW = $clog2(BUF_WORDS + 1);
    localparam int IW = $clog2(FLUSH_IDLE + 1);
    localparam logic [CW-1:0] C_FULL  = CW'(BUF_WORDS);
    localparam logic [CW-1:0] C_CLOSE = CW'(BUF_WORDS - 1);
    localparam logic [CW-1:0] C_ENMAX = CW'(BUF_WORDS - 2);
    localparam logic [IW-1:0] I_LAST  = IW'(FLUSH_IDLE - 1);

    typedef enum logic [2:0] {
        S_COLLECT,
        S_WAIT_SPACE,
        S_HDR,
        S_DATA,
        S_PAD
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_idx;
    logic [CW-1:0]   w_idx_nx;
    logic [IW-1:0]   r_idle;
    logic            r_ovr;
    logic [31:0]     r_ts;
    logic [15:0]     r_buf [BUF_WORDS];
    logic            r_wrreq;
    logic            r_pkt_done;
    logic [15:0]     r_wrdata;

    logic            w_store;
    logic            w_drop;
    logic            w_close;
    logic            w_wr;
    logic            w_last;
    logic [15:0]     w_hdr;
    logic [8:0]      w_bytes;

    assign w_store = bus.rx_WR && (r_state == S_COLLECT) && (r_count < C_FULL);
    assign w_drop  = bus.rx_WR && !w_store;
    assign w_bytes = 9'({r_count, 1'b0});
    assign w_close = (r_count >= C_CLOSE) ||
                     ((r_count != '0) && bus.rx_WR_done && (r_idle == I_LAST));

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_wr       = 1'b0;
        w_last     = 1'b0;
        w_hdr      = '0;
        unique case (r_state)
            S_COLLECT: begin
                if (w_close) w_state_nx = S_WAIT_SPACE;
            end
            S_WAIT_SPACE: begin
                if (bus.pkt_space) begin
                    w_state_nx = S_HDR;
                    w_idx_nx   = '0;
                end
            end
            S_HDR: begin
                w_wr = 1'b1;
                unique case (r_idx[1:0])
                    2'd0:    w_hdr = {r_ovr, 6'd0, w_bytes};
                    2'd1:    w_hdr = {11'd0, CHAN};
                    2'd2:    w_hdr = r_ts[15:0];
                    default: w_hdr = r_ts[31:16];
                endcase
                // w3 cycle also issues the buf[0] read so data follows gaplessly
                if (r_idx[1:0] == 2'd3) begin
                    w_state_nx = S_DATA;
                    w_idx_nx   = '0;
                end else begin
                    w_idx_nx = r_idx + 1'b1;
                end
            end
            S_DATA: begin
                w_wr = 1'b1;
                if (r_idx == r_count - 1'b1) begin
`ifdef REPLY_PAD_EN
                    if (r_count == C_FULL) begin
                        w_last     = 1'b1;
                        w_state_nx = S_COLLECT;
                    end else begin
                        w_state_nx = S_PAD;
                        w_idx_nx   = r_idx + 1'b1;
                    end
`else
                    w_last     = 1'b1;
                    w_state_nx = S_COLLECT;
`endif
                end else begin
                    w_idx_nx = r_idx + 1'b1;
                end
            end
            S_PAD: begin
                w_wr = 1'b1;
                if (r_idx == C_CLOSE) begin
                    w_last     = 1'b1;
                    w_state_nx = S_COLLECT;
                end else begin
                    w_idx_nx = r_idx + 1'b1;
                end
            end
            default: w_state_nx = S_COLLECT;
        endcase
    end

    always_ff @(posedge txclk or negedge reset) begin
        if (!reset) begin
            r_state <= S_COLLECT;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
        end
    end

    always_ff @(posedge txclk or negedge reset) begin
        if (!reset) begin
            r_count    <= '0;
            r_ovr      <= 1'b0;
            r_ts       <= '0;
            r_idle     <= '0;
            r_wrreq    <= 1'b0;
            r_pkt_done <= 1'b0;
            r_wrdata   <= '0;
        end else begin
            if (w_last) r_count <= '0;
            else if (w_store) r_count <= r_count + 1'b1;
            // a drop during HDR/DATA belongs to the following packet
            if (w_drop) r_ovr <= 1'b1;
            else if (r_state == S_HDR && r_idx == '0) r_ovr <= 1'b0;
            if (w_store && r_count == '0) r_ts <= adc_time;
            if (bus.rx_WR || !bus.rx_WR_done) r_idle <= '0;
            else if (r_idle != I_LAST) r_idle <= r_idle + 1'b1;
            r_wrreq    <= w_wr;
            r_pkt_done <= w_last;
            r_wrdata   <= (r_state == S_DATA) ? r_buf[r_idx] : w_hdr;
        end
    end

    always_ff @(posedge txclk) begin
        if (w_store) r_buf[r_count] <= bus.rx_databus;
    end

    assign bus.rx_WR_enabled = (r_state == S_COLLECT) && (r_count <= C_ENMAX);
    assign bus.wrreq         = r_wrreq;
    assign bus.wrdata        = r_wrdata;
    assign bus.pkt_done      = r_pkt_done;

endmodule

// File: tb/tb_cmd_reply_packer.sv
// Directed self-checking bench for cmd_reply_packer.
// Expected packet lengths follow REPLY_PAD_EN when it is defined.
module tb_cmd_reply_packer;

    logic        txclk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] adc_time;

    cmd_reply_packer_if ifc ();

    cmd_reply_packer dut (
        .txclk    (txclk),
        .reset    (reset),
        .adc_time (adc_time),
        .bus      (ifc)
    );

    always #5 txclk = ~txclk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] got [0:299];
    int          got_n;
    bit          gap;
    logic [15:0] exp_d [$];

    task automatic step();
        @(posedge txclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int plen(input int c);
`ifdef REPLY_PAD_EN
        return 256;
`else
        return 4 + c;
`endif
    endfunction

    task automatic wait_wr(input int budget, output int lat);
        lat = 0;
        while (ifc.wrreq !== 1'b1 && lat < budget) begin
            step();
            lat++;
        end
    endtask

    task automatic get_pkt();
        int n;
        n   = 0;
        gap = 0;
        while (n < 300) begin
            if (ifc.wrreq !== 1'b1) begin
                gap = 1;
                break;
            end
            got[n] = ifc.wrdata;
            n++;
            if (ifc.pkt_done === 1'b1) break;
            step();
        end
        got_n = n;
    endtask

    task automatic send_pair(input logic [15:0] a, input logic [15:0] b);
        ifc.rx_WR      = 1'b1;
        ifc.rx_databus = a;
        step();
        ifc.rx_databus = b;
        step();
        ifc.rx_WR = 1'b0;
    endtask

    task automatic check_pkt(input string tag, input logic [15:0] w0,
                             input logic [31:0] ts);
        int bad;
        int nz;
        bad = 0;
        nz  = 0;
        chk({tag, "_w0"}, 32'(got[0]), 32'(w0));
        chk({tag, "_w1"}, 32'(got[1]), 32'h001F);
        chk({tag, "_w2"}, 32'(got[2]), 32'(ts[15:0]));
        chk({tag, "_w3"}, 32'(got[3]), 32'(ts[31:16]));
        chk({tag, "_len"}, 32'(got_n), 32'(plen(exp_d.size())));
        chk({tag, "_gap"}, 32'(gap), 32'd0);
        for (int i = 0; i < exp_d.size(); i++)
            if (4 + i >= got_n || got[4+i] !== exp_d[i]) bad++;
        chk({tag, "_data"}, 32'(bad), 32'd0);
        for (int i = 4 + exp_d.size(); i < got_n; i++)
            if (got[i] !== 16'h0000) nz++;
        chk({tag, "_pad"}, 32'(nz), 32'd0);
    endtask

    initial begin
        int lat;
        int bad_en;

        ifc.rx_WR      = 1'b0;
        ifc.rx_databus = '0;
        ifc.rx_WR_done = 1'b1;
        ifc.pkt_space  = 1'b1;
        adc_time       = '0;
        repeat (3) step();
        chk("rst_wrreq", 32'(ifc.wrreq), 32'd0);
        chk("rst_wrdata", 32'(ifc.wrdata), 32'd0);
        chk("rst_done", 32'(ifc.pkt_done), 32'd0);
        chk("rst_en", 32'(ifc.rx_WR_enabled), 32'd1);
        reset = 1'b1;
        step();

        // ping reply
        adc_time       = 32'h0000_0100;
        ifc.rx_WR      = 1'b1;
        ifc.rx_databus = 16'h1234;
        step();
        adc_time       = 32'h0000_0101;
        ifc.rx_databus = 16'h0102;
        step();
        ifc.rx_WR = 1'b0;
        wait_wr(40, lat);
        chk("ping_lat", 32'(lat), 32'd18);
        get_pkt();
        exp_d = '{16'h1234, 16'h0102};
        check_pkt("ping", 16'h0004, 32'h0000_0100);
        step();
        chk("ping_en_after", 32'(ifc.rx_WR_enabled), 32'd1);

        // register read, split by rx_WR_done=0
        ifc.rx_WR_done = 1'b0;
        adc_time       = 32'h0000_2345;
        send_pair(16'hA001, 16'hA002);
        adc_time = 32'h0000_3000;
        wait_wr(20, lat);
        chk("rr_noclose", 32'(lat), 32'd20);
        send_pair(16'hA003, 16'hA004);
        ifc.rx_WR_done = 1'b1;
        wait_wr(40, lat);
        chk("rr_lat", 32'(lat), 32'd18);
        get_pkt();
        exp_d = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
        check_pkt("rr", 16'h0008, 32'h0000_2345);
        step();

        // fill: 126 back-to-back pairs, no idle timeout possible
        ifc.rx_WR_done = 1'b0;
        adc_time       = 32'hDEAD_BEEF;
        bad_en         = 0;
        exp_d          = {};
        ifc.rx_WR      = 1'b1;
        for (int i = 0; i < 252; i++) begin
            ifc.rx_databus = 16'h5000 + 16'(i);
            exp_d.push_back(16'h5000 + 16'(i));
            if (i % 2 == 0 && ifc.rx_WR_enabled !== 1'b1) bad_en++;
            step();
            adc_time = 32'h1111_0000;
        end
        ifc.rx_WR = 1'b0;
        chk("fill_en_low_early", 32'(bad_en), 32'd0);
        chk("fill_en_fall", 32'(ifc.rx_WR_enabled), 32'd0);
        wait_wr(10, lat);
        chk("fill_lat", 32'(lat), 32'd2);
        get_pkt();
        check_pkt("fill", 16'h01F8, 32'hDEAD_BEEF);
        step();
        ifc.rx_WR_done = 1'b1;

        // overrun and backpressure
        ifc.pkt_space = 1'b0;
        adc_time      = 32'h0000_0042;
        send_pair(16'hB001, 16'hB002);
        wait_wr(30, lat);
        chk("ovr_hold1", 32'(lat), 32'd30);
        chk("ovr_en_wait", 32'(ifc.rx_WR_enabled), 32'd0);
        ifc.rx_WR      = 1'b1;
        ifc.rx_databus = 16'hBBBB;
        step();
        ifc.rx_WR = 1'b0;
        wait_wr(50, lat);
        chk("ovr_hold2", 32'(lat), 32'd50);
        ifc.pkt_space = 1'b1;
        wait_wr(10, lat);
        chk("ovr_lat", 32'(lat), 32'd2);
        get_pkt();
        exp_d = '{16'hB001, 16'hB002};
        check_pkt("ovr", 16'h8004, 32'h0000_0042);
        step();

        adc_time = 32'h0000_0055;
        send_pair(16'hC001, 16'hC002);
        wait_wr(40, lat);
        chk("post_lat", 32'(lat), 32'd18);
        get_pkt();
        exp_d = '{16'hC001, 16'hC002};
        check_pkt("post", 16'h0004, 32'h0000_0055);
        step();

        // reset in the middle of DATA
        adc_time = 32'h0000_0777;
        send_pair(16'hD001, 16'hD002);
        send_pair(16'hD003, 16'hD004);
        send_pair(16'hD005, 16'hD006);
        send_pair(16'hD007, 16'hD008);
        wait_wr(40, lat);
        chk("mid_lat", 32'(lat), 32'd18);
        repeat (9) step();
        chk("mid_word10", 32'(ifc.wrdata), 32'hD006);
        reset = 1'b0;
        #1;
        chk("mid_wrreq_drop", 32'(ifc.wrreq), 32'd0);
        step();
        step();
        reset = 1'b1;
        step();
        chk("mid_en_after", 32'(ifc.rx_WR_enabled), 32'd1);
        chk("mid_wrreq_after", 32'(ifc.wrreq), 32'd0);
        adc_time = 32'h0000_0999;
        send_pair(16'hE001, 16'hE002);
        wait_wr(40, lat);
        chk("fresh_lat", 32'(lat), 32'd18);
        get_pkt();
        exp_d = '{16'hE001, 16'hE002};
        check_pkt("fresh", 16'h0004, 32'h0000_0999);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
